// File: rtl/display_pkg.sv
// display_pkg
// Shared types and constants for the display timing detector.
//   det_state_t : detector FSM states (SEARCH, MEASURE, CONFIRM, LOCKED)
//   CNT_W_DEF   : default width of measurement counters and outputs
//   SNAP_W      : field width of a stored snapshot; counters of up to
//                 SNAP_W bits are zero-extended into it
//   snapshot_t  : one frame's measurements taken at a vsync leading edge
package display_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int SNAP_W    = 32;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } det_state_t;

  typedef struct packed {
    logic [SNAP_W-1:0] line_total;
    logic [SNAP_W-1:0] line_res;
    logic [SNAP_W-1:0] frame_total;
    logic [SNAP_W-1:0] frame_act;
  } snapshot_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Registers one input bit and flags its transitions, comparing the
// registered value with its previous copy.
//   i_clk  : clock
//   i_rst  : synchronous reset, active high (clears both stages)
//   i_d    : raw input
//   o_q    : registered input
//   o_rise : registered value went 0 -> 1 (one-cycle pulse)
//   o_fall : registered value went 1 -> 0 (one-cycle pulse)
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_q_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q   <= 1'b0;
      r_q_d <= 1'b0;
    end else begin
      r_q   <= i_d;
      r_q_d <= r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_q & ~r_q_d;
  assign o_fall = ~r_q & r_q_d;

endmodule

// File: rtl/display_timing_detect.sv
// display_timing_detect
// Watches an hs/vs/de stream, detects sync polarity, measures line/frame
// active and total sizes and locks once two consecutive frames agree.
//   i_pix_clk : pixel clock (only clock)
//   i_rst     : synchronous reset, active high
//   i_hs/i_vs : syncs of either polarity; i_de : display enable, active high
//   o_hs_pol/o_vs_pol : detected polarity (1 = positive)
//   o_h_res/o_v_res   : active pixels per line / active lines per frame
//   o_h_total/o_v_total : clocks per line / lines per frame
//   o_locked  : measurements stable; o_frame : pulse per vsync leading edge
// Build option: define DISPLAY_TIMING_DETECT_TIMEOUT_EN to add a watchdog
// that drops lock after TIMEOUT clocks without an hsync leading edge.
module display_timing_detect
  import display_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic             i_pix_clk,
  input  logic             i_rst,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  output logic             o_hs_pol,
  output logic             o_vs_pol,
  output logic [CNT_W-1:0] o_h_res,
  output logic [CNT_W-1:0] o_v_res,
  output logic [CNT_W-1:0] o_h_total,
  output logic [CNT_W-1:0] o_v_total,
  output logic             o_locked,
  output logic             o_frame
);

  // bit 0: hs, bit 1: vs, bit 2: de
  logic [2:0] w_in;
  logic [2:0] w_lvl;
  logic [2:0] w_rise;
  logic [2:0] w_fall;

  assign w_in = {i_de, i_vs, i_hs};

  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    sync_edge_detect u_edge (
      .i_clk  (i_pix_clk),
      .i_rst  (i_rst),
      .i_d    (w_in[gi]),
      .o_q    (w_lvl[gi]),
      .o_rise (w_rise[gi]),
      .o_fall (w_fall[gi])
    );
  end

  logic r_pol_valid;
  logic w_hs_lead;
  logic w_vs_lead;
  logic w_de_rise;
  logic w_de_fall;
  logic w_pol_change;
  logic w_timeout;

  // A leading edge is the transition into the active level for the current polarity.
  assign w_hs_lead = o_hs_pol ? w_rise[0] : w_fall[0];
  assign w_vs_lead = o_vs_pol ? w_rise[1] : w_fall[1];
  assign w_de_rise = w_rise[2];
  assign w_de_fall = w_fall[2];

  // Syncs are inactive during active video, so their level at DE rise is the
  // inverse of the active polarity.
  assign w_pol_change = w_de_rise && r_pol_valid &&
                        ({~w_lvl[0], ~w_lvl[1]} != {o_hs_pol, o_vs_pol});

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------- measurement counters ----------------
  logic [CNT_W-1:0] r_h_cnt, r_de_run, r_v_cnt, r_v_act;
  logic [CNT_W-1:0] r_line_total, r_line_res, r_frame_total, r_frame_act;
  logic [CNT_W-1:0] w_h_cnt_next, w_de_run_next, w_v_cnt_next, w_v_act_next;
  logic [CNT_W-1:0] w_line_total_next, w_line_res_next;
  logic [CNT_W-1:0] w_frame_total_next, w_frame_act_next;

  always_comb begin
    w_h_cnt_next       = sat_inc(r_h_cnt);
    w_de_run_next      = r_de_run;
    w_v_cnt_next       = r_v_cnt;
    w_v_act_next       = r_v_act;
    w_line_total_next  = r_line_total;
    w_line_res_next    = r_line_res;
    w_frame_total_next = r_frame_total;
    w_frame_act_next   = r_frame_act;

    if (w_hs_lead) begin
      w_line_total_next = r_h_cnt;
      w_h_cnt_next      = CNT_W'(1);
      w_v_cnt_next      = sat_inc(r_v_cnt);
    end

    if (w_de_rise) begin
      w_de_run_next = CNT_W'(1);
      w_v_act_next  = sat_inc(r_v_act);
    end else if (w_lvl[2]) begin
      w_de_run_next = sat_inc(r_de_run);
    end

    if (w_de_fall) begin
      w_line_res_next = r_de_run;
    end

    // Frame latch uses the already-incremented line count, so a line starting
    // on the same clock as vsync belongs to the frame that is ending.
    if (w_vs_lead) begin
      w_frame_total_next = w_v_cnt_next;
      w_frame_act_next   = w_v_act_next;
      w_v_cnt_next       = '0;
      w_v_act_next       = '0;
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      r_h_cnt       <= '0;
      r_de_run      <= '0;
      r_v_cnt       <= '0;
      r_v_act       <= '0;
      r_line_total  <= '0;
      r_line_res    <= '0;
      r_frame_total <= '0;
      r_frame_act   <= '0;
    end else begin
      r_h_cnt       <= w_h_cnt_next;
      r_de_run      <= w_de_run_next;
      r_v_cnt       <= w_v_cnt_next;
      r_v_act       <= w_v_act_next;
      r_line_total  <= w_line_total_next;
      r_line_res    <= w_line_res_next;
      r_frame_total <= w_frame_total_next;
      r_frame_act   <= w_frame_act_next;
    end
  end

  snapshot_t w_snap;

  always_comb begin
    w_snap.line_total  = SNAP_W'(w_line_total_next);
    w_snap.line_res    = SNAP_W'(w_line_res_next);
    w_snap.frame_total = SNAP_W'(w_frame_total_next);
    w_snap.frame_act   = SNAP_W'(w_frame_act_next);
  end

  // ---------------- optional hsync watchdog ----------------
`ifdef DISPLAY_TIMING_DETECT_TIMEOUT_EN
  logic [31:0] r_wd;

  // Holds at TIMEOUT so the timeout fires once per hsync loss.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst || w_hs_lead) begin
      r_wd <= '0;
    end else if (r_wd != 32'(TIMEOUT)) begin
      r_wd <= r_wd + 32'd1;
    end
  end

  assign w_timeout = !w_hs_lead && (r_wd == 32'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
`endif

  // ---------------- polarity ----------------
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      o_hs_pol    <= 1'b0;
      o_vs_pol    <= 1'b0;
      r_pol_valid <= 1'b0;
    end else if (w_de_rise) begin
      o_hs_pol    <= ~w_lvl[0];
      o_vs_pol    <= ~w_lvl[1];
      r_pol_valid <= 1'b1;
    end else if (w_timeout) begin
      r_pol_valid <= 1'b0;
    end
  end

  // ---------------- lock FSM ----------------
  det_state_t r_state, w_state_next;
  snapshot_t  r_snap, w_snap_next;
  logic       w_publish;

  always_comb begin
    w_state_next = r_state;
    w_snap_next  = r_snap;
    w_publish    = 1'b0;
    case (r_state)
      SEARCH: begin
        if (r_pol_valid && w_vs_lead) w_state_next = MEASURE;
      end
      MEASURE: begin
        if (w_vs_lead) begin
          w_snap_next  = w_snap;
          w_state_next = CONFIRM;
        end
      end
      CONFIRM: begin
        if (w_vs_lead) begin
          if (w_snap == r_snap) begin
            w_state_next = LOCKED;
            w_publish    = 1'b1;
          end else begin
            w_snap_next = w_snap;
          end
        end
      end
      LOCKED: begin
        if (w_vs_lead && (w_snap != r_snap)) begin
          w_snap_next  = w_snap;
          w_state_next = CONFIRM;
        end
      end
      default: w_state_next = SEARCH;
    endcase
    if (w_pol_change || w_timeout) begin
      w_state_next = SEARCH;
      w_publish    = 1'b0;
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      r_state   <= SEARCH;
      r_snap    <= '0;
      o_h_res   <= '0;
      o_v_res   <= '0;
      o_h_total <= '0;
      o_v_total <= '0;
      o_frame   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_snap  <= w_snap_next;
      o_frame <= w_vs_lead;
      // Published values change only on lock and hold through lock loss.
      if (w_publish) begin
        o_h_res   <= CNT_W'(r_snap.line_res);
        o_v_res   <= CNT_W'(r_snap.frame_act);
        o_h_total <= CNT_W'(r_snap.line_total);
        o_v_total <= CNT_W'(r_snap.frame_total);
      end
    end
  end

  assign o_locked = (r_state == LOCKED);

endmodule

// File: tb/tb_display_timing_detect.sv
module tb_display_timing_detect;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hs  = 1'b1;
  logic             vs  = 1'b1;
  logic             de  = 1'b0;
  logic             hs_pol, vs_pol, locked, frame;
  logic [CNT_W-1:0] h_res, v_res, h_total, v_total;

  always #5 clk = ~clk;

  display_timing_detect #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_pix_clk (clk),
    .i_rst     (rst),
    .i_hs      (hs),
    .i_vs      (vs),
    .i_de      (de),
    .o_hs_pol  (hs_pol),
    .o_vs_pol  (vs_pol),
    .o_h_res   (h_res),
    .o_v_res   (v_res),
    .o_h_total (h_total),
    .o_v_total (v_total),
    .o_locked  (locked),
    .o_frame   (frame)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s got=%0d", tag, got);
    end
  endtask

  // ---------------- stream generator ----------------
  // Line: active, front porch, sync, back porch. Frame likewise in lines.
  // New settings take effect at the next frame start.
  int cfg_hr = 40, cfg_hfp = 4, cfg_hsw = 6, cfg_hbp = 10;
  int cfg_vr = 20, cfg_vfp = 2, cfg_vsw = 3, cfg_vbp = 5;
  bit cfg_pol = 1'b0;
  int cur_hr, cur_hfp, cur_hsw, cur_hbp, cur_vr, cur_vfp, cur_vsw, cur_vbp;
  bit cur_pol = 1'b0;
  bit gen_run = 1'b1;
  int gx = 0, gy = 0;
  int cyc = 0;
  int hs_p0 = 0;
  bit tb_hs_act = 1'b0;
  bit tb_vs_act = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (gen_run) begin
        if (gx == 0 && gy == 0) begin
          cur_hr = cfg_hr; cur_hfp = cfg_hfp; cur_hsw = cfg_hsw; cur_hbp = cfg_hbp;
          cur_vr = cfg_vr; cur_vfp = cfg_vfp; cur_vsw = cfg_vsw; cur_vbp = cfg_vbp;
          cur_pol = cfg_pol;
        end
        de = (gx < cur_hr) && (gy < cur_vr);
        if ((gx >= cur_hr + cur_hfp) && (gx < cur_hr + cur_hfp + cur_hsw)) begin
          if (!tb_hs_act) hs_p0 = cyc;
          tb_hs_act = 1'b1;
        end else begin
          tb_hs_act = 1'b0;
        end
        tb_vs_act = (gy >= cur_vr + cur_vfp) && (gy < cur_vr + cur_vfp + cur_vsw);
        hs = tb_hs_act ? cur_pol : !cur_pol;
        vs = tb_vs_act ? cur_pol : !cur_pol;
        gx++;
        if (gx == cur_hr + cur_hfp + cur_hsw + cur_hbp) begin
          gx = 0;
          gy++;
          if (gy == cur_vr + cur_vfp + cur_vsw + cur_vbp) gy = 0;
        end
      end else begin
        tb_hs_act = 1'b0;
        tb_vs_act = 1'b0;
        de = 1'b0;
        hs = !cur_pol;
        vs = !cur_pol;
      end
    end
  end

  // ---------------- helpers ----------------
  // Waits for the bench-side vsync to turn active, then checks the
  // two-clock o_frame latency and one-cycle width.
  task automatic check_frame_latency(input string tag);
    int n = 0;
    while (tb_vs_act && n < 5000) begin @(negedge clk); n++; end
    while (!tb_vs_act && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_wait"}, 32'(n < 5000), 1);
    chk({tag, "_d0"}, 32'(frame), 0);
    @(negedge clk);
    chk({tag, "_d1"}, 32'(frame), 0);
    @(negedge clk);
    chk({tag, "_d2"}, 32'(frame), 1);
    @(negedge clk);
    chk({tag, "_d3"}, 32'(frame), 0);
  endtask

  // Waits for o_locked, counting o_frame pulses on the way; optionally
  // checks that lock rose together with the expected pulse number.
  task automatic wait_lock(input string tag, input int already, input bit do_count,
                           input int exp_frames, input int limit);
    int n = 0;
    int frames = already;
    while (!locked && n < limit) begin
      @(negedge clk);
      n++;
      if (frame) frames++;
    end
    chk({tag, "_wait"}, 32'(n < limit), 1);
    if (do_count) begin
      chk({tag, "_frames"}, 32'(frames), 32'(exp_frames));
      chk({tag, "_with_frame"}, 32'(frame), 1);
    end
  endtask

  task automatic wait_frame(input string tag, input int limit);
    int n = 0;
    while (!frame && n < limit) begin @(negedge clk); n++; end
    chk({tag, "_wait"}, 32'(n < limit), 1);
  endtask

  task automatic check_meas(input string tag, input int pol, input int hr, input int ht,
                            input int vr, input int vt);
    chk({tag, "_hs_pol"}, 32'(hs_pol), 32'(pol));
    chk({tag, "_vs_pol"}, 32'(vs_pol), 32'(pol));
    chk({tag, "_h_res"}, 32'(h_res), 32'(hr));
    chk({tag, "_h_total"}, 32'(h_total), 32'(ht));
    chk({tag, "_v_res"}, 32'(v_res), 32'(vr));
    chk({tag, "_v_total"}, 32'(v_total), 32'(vt));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic prev_locked;
    int n;

    // Reset state
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_frame", 32'(frame), 0);
    chk("rst_h_res", 32'(h_res), 0);
    chk("rst_v_total", 32'(v_total), 0);

    // Negative-polarity 60x30 (40x20 active): frame latency before lock,
    // lock on the third vsync leading edge.
    check_frame_latency("t1_frame_lat");
    chk("t1_unlocked_pre", 32'(locked), 0);
    wait_lock("t1_lock", 1, 1'b1, 3, 8000);
    check_meas("t1", 0, 40, 60, 20, 30);

    // Small positive-polarity timing: 25x13 total, 16x8 active
    cfg_hr = 16; cfg_hfp = 2; cfg_hsw = 3; cfg_hbp = 4;
    cfg_vr = 8;  cfg_vfp = 1; cfg_vsw = 2; cfg_vbp = 2;
    cfg_pol = 1'b1;
    n = 0;
    while (locked && n < 5000) begin @(negedge clk); n++; end
    chk("t2_unlock_wait", 32'(n < 5000), 1);
    wait_lock("t2_lock", 0, 1'b0, 0, 3000);
    check_meas("t2", 1, 16, 25, 8, 13);

    // V_RES 8 -> 10 while locked: lock drops with the next vsync edge
    wait_frame("t3_sync", 1000);
    @(negedge clk);
    cfg_vr = 10;
    n = 0;
    prev_locked = locked;
    while (!frame && n < 1000) begin
      prev_locked = locked;
      @(negedge clk);
      n++;
    end
    chk("t3_frame_wait", 32'(n < 1000), 1);
    chk("t3_locked_before", 32'(prev_locked), 1);
    chk("t3_unlock_at_edge", 32'(locked), 0);
    chk("t3_v_res_held", 32'(v_res), 8);
    wait_lock("t3_relock", 0, 1'b0, 0, 2000);
    check_meas("t3", 1, 16, 25, 10, 15);

    // One-clock reset mid-frame while locked
    repeat (160) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_meas("t4_rst", 0, 0, 0, 0, 0);
    chk("t4_rst_locked", 32'(locked), 0);
    chk("t4_rst_frame", 32'(frame), 0);
    wait_lock("t4_relock", 0, 1'b1, 3, 2000);
    check_meas("t4", 1, 16, 25, 10, 15);

    // Stop hsync while locked
    gen_run = 1'b0;
    n = 0;
    while (cyc < hs_p0 + 65 && n < 500) begin @(negedge clk); n++; end
    chk("t5_wait", 32'(n < 500), 1);
    chk("t5_locked_before_to", 32'(locked), 1);
    @(negedge clk);
`ifdef DISPLAY_TIMING_DETECT_TIMEOUT_EN
    chk("t5_locked_at_to", 32'(locked), 0);
`else
    chk("t5_locked_at_to", 32'(locked), 1);
`endif
    repeat (100) @(negedge clk);
`ifdef DISPLAY_TIMING_DETECT_TIMEOUT_EN
    chk("t5_locked_late", 32'(locked), 0);
`else
    chk("t5_locked_late", 32'(locked), 1);
`endif
    chk("t5_h_res_held", 32'(h_res), 16);
    chk("t5_v_total_held", 32'(v_total), 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
